// File: rtl/paralelo_serial_tx_if.sv
// paralelo_serial_tx_if: word handshake into the serialiser (data_in/valid_in/force_resync in, ready_out back)
interface paralelo_serial_tx_if;
  logic [7:0] data_in;
  logic       valid_in;
  logic       force_resync;
  logic       ready_out;
  modport master(output data_in, valid_in, force_resync, input ready_out);
  modport slave(input data_in, valid_in, force_resync, output ready_out);
endinterface

// File: rtl/paralelo_serial_tx.sv
// paralelo_serial_tx: MSB-first byte serialiser with comma preamble (clk_32f, reset, bus handshake in; serial_out, active_out, err_comma out)
module paralelo_serial_tx #(
  parameter int         SYNC_COMMAS = 4,
  parameter logic [7:0] COMMA       = 8'hBC
) (
  input  logic                  clk_32f,
  input  logic                  reset,
  paralelo_serial_tx_if.slave   bus,
  output logic                  serial_out,
  output logic                  active_out,
  output logic                  err_comma
);
  typedef enum logic {SYNC, DATA} state_e;
  localparam logic [3:0] SYNC_N = 4'(SYNC_COMMAS);
  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q;
  logic [3:0] sync_cnt_q, sync_cnt_d;
  logic       pend_q, pend_d;
  logic [7:0] sr_q, sr_d, byte_sel;
  logic       serial_q, serial_d, err_q, err_d, load, ready;
  assign load = bit_cnt_q == 3'd0;
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state_q    <= SYNC;
      bit_cnt_q  <= '0;
      sync_cnt_q <= '0;
      pend_q     <= 1'b0;
      sr_q       <= '0;
      serial_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_q + 3'd1;
      sync_cnt_q <= sync_cnt_d;
      pend_q     <= pend_d;
      sr_q       <= sr_d;
      serial_q   <= serial_d;
      err_q      <= err_d;
    end
  end
  // Resync requests are held until the byte boundary so no byte is truncated.
  always_comb begin
    state_d    = state_q;
    sync_cnt_d = sync_cnt_q;
    pend_d     = pend_q | bus.force_resync;
    if (state_q == SYNC && load) sync_cnt_d = sync_cnt_q + 4'd1;
    if (bit_cnt_q == 3'd7) begin
      if (pend_d) begin
        state_d    = SYNC;
        sync_cnt_d = '0;
        pend_d     = 1'b0;
      end else if (state_q == SYNC && sync_cnt_q == SYNC_N) begin
        state_d    = DATA;
        sync_cnt_d = '0;
      end
    end
  end
  always_comb begin
    ready    = state_q == DATA && load && !reset;
    byte_sel = ready && bus.valid_in ? bus.data_in : COMMA;
    serial_d = load ? byte_sel[7] : sr_q[7];
    sr_d     = load ? {byte_sel[6:0], 1'b0} : {sr_q[6:0], 1'b0};
    err_d    = ready && bus.valid_in && bus.data_in == COMMA;
  end
  assign bus.ready_out = ready;
  assign serial_out    = serial_q;
  assign active_out    = state_q == DATA;
  assign err_comma     = err_q;
endmodule

// File: tb/tb_paralelo_serial_tx.sv
// tb_paralelo_serial_tx: scoreboard bench for paralelo_serial_tx
module tb_paralelo_serial_tx;
  logic clk_32f = 1'b0;
  logic reset = 1'b1;
  logic serial_out, active_out, err_comma;
  int   errors = 0, checks = 0;
  bit   running = 1'b0;
  bit   q[$];
  paralelo_serial_tx_if bus();
  paralelo_serial_tx dut (
    .clk_32f(clk_32f),
    .reset(reset),
    .bus(bus.slave),
    .serial_out(serial_out),
    .active_out(active_out),
    .err_comma(err_comma)
  );
  always #5 clk_32f = ~clk_32f;
  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick;
    @(posedge clk_32f);
    #1;
  endtask
  task automatic push(logic [7:0] b, int lo);
    for (int i = 7; i >= lo; i--) q.push_back(b[i]);
  endtask
  always @(posedge clk_32f) begin
    logic r;
    r = reset;
    #2;
    if (!r) begin
      if (q.size() > 0) chk("serial_bit", 8'(serial_out), 8'(q.pop_front()));
      else if (running) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_underflow: got serial_out=%0b expected no bit at %0t", serial_out, $time);
      end
    end
  end
  task automatic preamble;
    for (int i = 0; i < 4; i++) push(8'hBC, 0);
    for (int e = 0; e < 32; e++) begin
      chk("ready_in_sync", 8'(bus.ready_out), 8'd0);
      tick;
      if (e == 30) chk("active_before_sync_end", 8'(active_out), 8'd0);
    end
    chk("active_after_sync", 8'(active_out), 8'd1);
  endtask
  task automatic send(bit v, logic [7:0] d);
    bus.valid_in = v;
    bus.data_in  = d;
    push(v ? d : 8'hBC, 0);
    chk("ready_at_load", 8'(bus.ready_out), 8'd1);
    tick;
    bus.valid_in = 1'b0;
    chk("err_comma_load", 8'(err_comma), 8'(v && d == 8'hBC));
    for (int e = 1; e < 8; e++) begin
      chk("ready_mid_byte", 8'(bus.ready_out), 8'd0);
      tick;
      if (e == 1) chk("err_comma_after", 8'(err_comma), 8'd0);
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
  initial begin
    bus.valid_in = 1'b0;
    bus.data_in = 8'h00;
    bus.force_resync = 1'b0;
    repeat (3) tick;
    chk("rst_serial", 8'(serial_out), 8'd0);
    chk("rst_ready", 8'(bus.ready_out), 8'd0);
    chk("rst_active", 8'(active_out), 8'd0);
    chk("rst_err", 8'(err_comma), 8'd0);
    reset = 1'b0;
    running = 1'b1;
    preamble;
    send(1'b1, 8'hA5);
    send(1'b0, 8'h77);
    send(1'b1, 8'h01);
    send(1'b1, 8'h80);
    send(1'b1, 8'hFF);
    send(1'b1, 8'hBC);
    bus.valid_in = 1'b1;
    bus.data_in = 8'h3C;
    push(8'h3C, 0);
    chk("ready_before_resync_byte", 8'(bus.ready_out), 8'd1);
    tick;
    bus.valid_in = 1'b0;
    tick;
    bus.force_resync = 1'b1;
    tick;
    bus.force_resync = 1'b0;
    repeat (5) tick;
    chk("active_after_resync", 8'(active_out), 8'd0);
    preamble;
    send(1'b1, 8'h5A);
    bus.valid_in = 1'b1;
    bus.data_in = 8'hC3;
    push(8'hC3, 5);
    tick;
    bus.valid_in = 1'b0;
    repeat (2) tick;
    reset = 1'b1;
    tick;
    chk("midrst_serial", 8'(serial_out), 8'd0);
    chk("midrst_ready", 8'(bus.ready_out), 8'd0);
    chk("midrst_active", 8'(active_out), 8'd0);
    tick;
    reset = 1'b0;
    preamble;
    send(1'b1, 8'hA5);
    running = 1'b0;
    tick;
    chk("scoreboard_drained", 8'(q.size()), 8'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
